// File: rtl/quad_decoder_counter_pkg.sv
// Shared constants and the x4 transition classifier for the quadrature decoder.
// The Gray states are listed in forward order (channel A leads).
package quad_pkg;

   localparam logic [1:0] S00 = 2'b00;
   localparam logic [1:0] S10 = 2'b10;
   localparam logic [1:0] S11 = 2'b11;
   localparam logic [1:0] S01 = 2'b01;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   typedef enum logic [1:0] {
      EV_NONE = 2'b00,
      EV_UP   = 2'b01,
      EV_DN   = 2'b10,
      EV_ERR  = 2'b11
   } quad_event_e;

   // Any single-bit change is a legal step.
   // Only the forward successor of prev counts up; every other single-bit change counts down.
   function automatic quad_event_e quad_decode(input logic [1:0] prev, input logic [1:0] cur);
      logic [1:0] fwd_next;
      case (prev)
         S00:     fwd_next = S10;
         S10:     fwd_next = S11;
         S11:     fwd_next = S01;
         default: fwd_next = S00;
      endcase
      if (prev == cur)
         return EV_NONE;
      else if ((prev ^ cur) == 2'b11)
         return EV_ERR;
      else if (cur == fwd_next)
         return EV_UP;
      else
         return EV_DN;
   endfunction

endpackage

// File: rtl/quad_decoder_counter_if.sv
// Encoder pins, position control and status of the quadrature decoder counter.
// The master modport drives the channels and controls; the slave is the counter.
interface quad_decoder_counter_if #(
   parameter int N = 8
);
   logic         a_in;
   logic         b_in;
   logic         syn_clr;
   logic         load;
   logic [N-1:0] d;
   logic         en;
   logic [N-1:0] q;
   logic         dir;
   logic         step_tick;
   logic         err_tick;
   logic         max_tick;
   logic         min_tick;

   modport master (
      output a_in, b_in, syn_clr, load, d, en,
      input  q, dir, step_tick, err_tick, max_tick, min_tick
   );

   modport slave (
      input  a_in, b_in, syn_clr, load, d, en,
      output q, dir, step_tick, err_tick, max_tick, min_tick
   );
endinterface

// File: rtl/quad_input_filter.sv
// One encoder channel: SYNC_STAGES-deep synchronizer followed by a stability filter
// that accepts a new level only after FILT_LEN consecutive differing samples.
module quad_input_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 3
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic filtered
);

   localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic [CW-1:0]          cnt;

   assign synced = sync_q[SYNC_STAGES-1];

   // Plain flop chain: no logic between stages so metastability has full cycles to resolve.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: state is assigned with <= so every flop samples pre-edge values, like real hardware.
      if (!reset_n)
         sync_q <= '0;
      else
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filtered <= 1'b0;
         cnt      <= '0;
      end else if (synced != filtered) begin
         if (cnt == LAST) begin
            filtered <= synced;
            cnt      <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else begin
         cnt <= '0;
      end
   end

endmodule

// File: rtl/quad_decoder_counter.sv
// x4 quadrature decoder driving an N-bit wrap-around position register.
// Decoding is held off after reset until the filters have settled on the pin levels.
module quad_decoder_counter
   import quad_pkg::*;
#(
   parameter int N           = 8,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 3
) (
   input logic                    clk,
   input logic                    reset_n,
   quad_decoder_counter_if.slave  bus
);

   localparam int STARTUP = SYNC_STAGES + FILT_LEN + 1;
   localparam int SW      = $clog2(STARTUP + 1);
   localparam logic [SW-1:0] START_LAST = SW'(STARTUP - 1);

   logic        a_filt;
   logic        b_filt;
   logic [1:0]  cur_state;
   logic [1:0]  prev_state;
   logic [SW-1:0] start_cnt;
   logic        armed;

   quad_event_e ev;
   logic        is_step;

   logic [N-1:0] q_r;
   logic [N-1:0] q_next;
   logic         dir_r;
   logic         step_r;
   logic         err_r;

   quad_input_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
   ) u_filt_a (
      .clk      (clk),
      .reset_n  (reset_n),
      .raw      (bus.a_in),
      .filtered (a_filt)
   );

   quad_input_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
   ) u_filt_b (
      .clk      (clk),
      .reset_n  (reset_n),
      .raw      (bus.b_in),
      .filtered (b_filt)
   );

   assign cur_state = {a_filt, b_filt};

   // prev tracks the filtered state even while unarmed, so arming never sees a stale edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_state <= S00;
         start_cnt  <= '0;
         armed      <= 1'b0;
      end else begin
         prev_state <= cur_state;
         if (!armed) begin
            if (start_cnt == START_LAST)
               armed <= 1'b1;
            else
               start_cnt <= start_cnt + 1'b1;
         end
      end
   end

   assign ev      = armed ? quad_decode(prev_state, cur_state) : EV_NONE;
   assign is_step = (ev == EV_UP) || (ev == EV_DN);

   always_comb begin
      // NOTE: default first so every path assigns q_next and no latch is inferred.
      q_next = q_r;
      if (bus.syn_clr)
         q_next = '0;
      else if (bus.load)
         q_next = bus.d;
      else if (bus.en && is_step)
         q_next = (ev == EV_UP) ? q_r + 1'b1 : q_r - 1'b1;
   end

   // Step/direction reporting is independent of en, clear and load.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_r    <= '0;
         dir_r  <= DIR_DN;
         step_r <= 1'b0;
         err_r  <= 1'b0;
      end else begin
         q_r    <= q_next;
         step_r <= is_step;
         err_r  <= (ev == EV_ERR);
         if (is_step)
            dir_r <= (ev == EV_UP) ? DIR_UP : DIR_DN;
      end
   end

   assign bus.q         = q_r;
   assign bus.dir       = dir_r;
   assign bus.step_tick = step_r;
   assign bus.err_tick  = err_r;
   assign bus.max_tick  = &q_r;
   assign bus.min_tick  = ~|q_r;

endmodule

// File: tb/tb_quad_decoder_counter.sv
// Directed bench for quad_decoder_counter at default parameters (6-edge latency).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_quad_decoder_counter;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;
   int   step_cnt;
   int   err_cnt;

   quad_decoder_counter_if #(.N(8)) bus ();

   quad_decoder_counter #(
      .N           (8),
      .SYNC_STAGES (2),
      .FILT_LEN    (3)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters sampled shortly after each rising edge.
   always @(posedge clk) begin
      #2;
      if (bus.step_tick === 1'b1) step_cnt++;
      if (bus.err_tick === 1'b1)  err_cnt++;
   end

   // Drive channels, hold 10 cycles; report step_tick before and at the 6th edge.
   task automatic move(input logic a, input logic b, output logic early, output logic at6);
      bus.a_in = a;
      bus.b_in = b;
      early = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (bus.step_tick !== 1'b0) early = 1'b1;
      end
      @(negedge clk);
      at6 = bus.step_tick;
      repeat (4) @(negedge clk);
   endtask

   task automatic do_reset(input logic a, input logic b);
      bus.a_in = a;
      bus.b_in = b;
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      int s0, e0;
      do_reset(1'b1, 1'b1);
      s0 = step_cnt; e0 = err_cnt;
      repeat (7) @(negedge clk);
      checks++; if (bus.q !== 8'h00) begin errors++; $display("FAIL reset_q: got %0h expected 00", bus.q); end
      checks++; if (bus.dir !== 1'b0) begin errors++; $display("FAIL reset_dir: got %0b expected 0", bus.dir); end
      checks++; if (bus.min_tick !== 1'b1) begin errors++; $display("FAIL reset_min: got %0b expected 1", bus.min_tick); end
      checks++; if (step_cnt - s0 != 0) begin errors++; $display("FAIL reset_steps: got %0d expected 0", step_cnt - s0); end
      checks++; if (err_cnt - e0 != 0) begin errors++; $display("FAIL reset_errs: got %0d expected 0", err_cnt - e0); end
   endtask

   task automatic test_forward();
      logic [1:0] seq [4];
      logic [7:0] exp_q [4];
      logic early, at6;
      int s0;
      seq   = '{2'b10, 2'b11, 2'b01, 2'b00};
      exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
      do_reset(1'b0, 1'b0);
      repeat (10) @(negedge clk);
      s0 = step_cnt;
      for (int i = 0; i < 4; i++) begin
         move(seq[i][1], seq[i][0], early, at6);
         checks++; if (early !== 1'b0) begin errors++; $display("FAIL fwd_early[%0d]: got %0b expected 0", i, early); end
         checks++; if (at6 !== 1'b1) begin errors++; $display("FAIL fwd_tick6[%0d]: got %0b expected 1", i, at6); end
         checks++; if (bus.q !== exp_q[i]) begin errors++; $display("FAIL fwd_q[%0d]: got %0h expected %0h", i, bus.q, exp_q[i]); end
      end
      checks++; if (bus.dir !== 1'b1) begin errors++; $display("FAIL fwd_dir: got %0b expected 1", bus.dir); end
      checks++; if (step_cnt - s0 != 4) begin errors++; $display("FAIL fwd_steps: got %0d expected 4", step_cnt - s0); end
   endtask

   task automatic test_load_reverse();
      logic [1:0] seq [3];
      logic [7:0] exp_q [3];
      logic early, at6;
      seq   = '{2'b01, 2'b11, 2'b10};
      exp_q = '{8'h01, 8'h00, 8'hFF};
      bus.d = 8'h02;
      bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      checks++; if (bus.q !== 8'h02) begin errors++; $display("FAIL load_q: got %0h expected 02", bus.q); end
      for (int i = 0; i < 3; i++) begin
         move(seq[i][1], seq[i][0], early, at6);
         checks++; if (at6 !== 1'b1) begin errors++; $display("FAIL rev_tick6[%0d]: got %0b expected 1", i, at6); end
         checks++; if (bus.q !== exp_q[i]) begin errors++; $display("FAIL rev_q[%0d]: got %0h expected %0h", i, bus.q, exp_q[i]); end
         checks++; if (bus.min_tick !== (i == 1)) begin errors++; $display("FAIL rev_min[%0d]: got %0b expected %0b", i, bus.min_tick, (i == 1)); end
         checks++; if (bus.max_tick !== (i == 2)) begin errors++; $display("FAIL rev_max[%0d]: got %0b expected %0b", i, bus.max_tick, (i == 2)); end
      end
      checks++; if (bus.dir !== 1'b0) begin errors++; $display("FAIL rev_dir: got %0b expected 0", bus.dir); end
   endtask

   task automatic test_glitch();
      int s0, e0;
      s0 = step_cnt; e0 = err_cnt;
      bus.a_in = 1'b0;
      repeat (2) @(negedge clk);
      bus.a_in = 1'b1;
      repeat (12) @(negedge clk);
      checks++; if (bus.q !== 8'hFF) begin errors++; $display("FAIL glitch_q: got %0h expected ff", bus.q); end
      checks++; if (step_cnt - s0 != 0) begin errors++; $display("FAIL glitch_steps: got %0d expected 0", step_cnt - s0); end
      checks++; if (err_cnt - e0 != 0) begin errors++; $display("FAIL glitch_errs: got %0d expected 0", err_cnt - e0); end
   endtask

   task automatic test_error_and_enable();
      logic early, at6;
      int s0, e0;
      move(1'b0, 1'b0, early, at6);
      checks++; if (bus.q !== 8'hFE) begin errors++; $display("FAIL pre_err_q: got %0h expected fe", bus.q); end
      e0 = err_cnt;
      move(1'b1, 1'b1, early, at6);
      checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL err_pulses: got %0d expected 1", err_cnt - e0); end
      checks++; if (at6 !== 1'b0) begin errors++; $display("FAIL err_step: got %0b expected 0", at6); end
      checks++; if (bus.q !== 8'hFE) begin errors++; $display("FAIL err_q: got %0h expected fe", bus.q); end
      checks++; if (bus.dir !== 1'b0) begin errors++; $display("FAIL err_dir: got %0b expected 0", bus.dir); end
      bus.en = 1'b0;
      s0 = step_cnt;
      move(1'b0, 1'b1, early, at6);
      move(1'b0, 1'b0, early, at6);
      bus.en = 1'b1;
      checks++; if (step_cnt - s0 != 2) begin errors++; $display("FAIL en0_steps: got %0d expected 2", step_cnt - s0); end
      checks++; if (bus.q !== 8'hFE) begin errors++; $display("FAIL en0_q: got %0h expected fe", bus.q); end
      checks++; if (bus.dir !== 1'b1) begin errors++; $display("FAIL en0_dir: got %0b expected 1", bus.dir); end
   endtask

   task automatic test_syn_clr();
      bus.d = 8'h10;
      bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      checks++; if (bus.q !== 8'h10) begin errors++; $display("FAIL clr_load_q: got %0h expected 10", bus.q); end
      bus.a_in = 1'b1;
      repeat (5) @(negedge clk);
      bus.syn_clr = 1'b1;
      @(negedge clk);
      bus.syn_clr = 1'b0;
      checks++; if (bus.q !== 8'h00) begin errors++; $display("FAIL clr_q: got %0h expected 00", bus.q); end
      checks++; if (bus.step_tick !== 1'b1) begin errors++; $display("FAIL clr_step: got %0b expected 1", bus.step_tick); end
      repeat (4) @(negedge clk);
      checks++; if (bus.q !== 8'h00) begin errors++; $display("FAIL clr_hold_q: got %0h expected 00", bus.q); end
   endtask

   task automatic test_reset_mid();
      logic early, at6;
      int s0, e0;
      move(1'b1, 1'b1, early, at6);
      checks++; if (bus.q !== 8'h01) begin errors++; $display("FAIL mid_pre_q: got %0h expected 01", bus.q); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if (bus.q !== 8'h00) begin errors++; $display("FAIL mid_async_q: got %0h expected 00", bus.q); end
      checks++; if (bus.dir !== 1'b0) begin errors++; $display("FAIL mid_async_dir: got %0b expected 0", bus.dir); end
      @(negedge clk);
      reset_n = 1'b1;
      s0 = step_cnt; e0 = err_cnt;
      repeat (20) @(negedge clk);
      checks++; if (step_cnt - s0 != 0) begin errors++; $display("FAIL rearm_steps: got %0d expected 0", step_cnt - s0); end
      checks++; if (err_cnt - e0 != 0) begin errors++; $display("FAIL rearm_errs: got %0d expected 0", err_cnt - e0); end
      move(1'b0, 1'b1, early, at6);
      checks++; if (at6 !== 1'b1) begin errors++; $display("FAIL rearm_tick6: got %0b expected 1", at6); end
      checks++; if (bus.q !== 8'h01) begin errors++; $display("FAIL rearm_q: got %0h expected 01", bus.q); end
   endtask

   initial begin
      checks = 0; errors = 0; step_cnt = 0; err_cnt = 0;
      reset_n = 1'b1;
      bus.a_in = 1'b0; bus.b_in = 1'b0;
      bus.syn_clr = 1'b0; bus.load = 1'b0; bus.d = 8'h00; bus.en = 1'b1;
      #2 reset_n = 1'b0;
      test_reset();
      test_forward();
      test_load_reverse();
      test_glitch();
      test_error_and_enable();
      test_syn_clr();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
